// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared pipeline types and constants for the fetch stage.
//               The SYNC state only exists when IFETCH_SYNC_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

   typedef logic [31:0] addr_t;

   // sll $0,$0,0
   localparam logic [31:0] c_nop_ins  = 32'h0000_0000;
   localparam addr_t       c_reset_pc = 32'h0000_0000;

`ifdef IFETCH_SYNC_EN
   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MEMWAIT = 2'd1,
      ST_SYNC    = 2'd2
   } if_state_e;
`else
   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MEMWAIT = 2'd1
   } if_state_e;
`endif

   function automatic addr_t word_align(input addr_t a);
      return a & ~32'h0000_0003;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ifid_reg.sv
// ============================================================================
// Module      : ifid_reg
// Description : IF/ID pipeline register with load / hold / flush controls.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ifid_reg
   import cpu_pkg::*;
#(
   parameter logic [31:0] NOP_INS = c_nop_ins
)
(
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic        i_flush,
   input  logic [31:0] i_ins,
   input  addr_t       i_pc,
   output logic [31:0] o_ins,
   output addr_t       o_pc,
   output addr_t       o_pc_plus4,
   output logic        o_valid
);

   logic [31:0] r_ins;
   addr_t       r_pc;
   addr_t       r_pc_plus4;
   logic        r_valid;

   // Flush leaves the address fields alone; only the word and valid matter.
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         r_ins      <= NOP_INS;
         r_pc       <= 32'h0000_0000;
         r_pc_plus4 <= 32'h0000_0004;
         r_valid    <= 1'b0;
      end else if (i_flush) begin
         r_ins      <= NOP_INS;
         r_valid    <= 1'b0;
      end else if (i_load) begin
         r_ins      <= i_ins;
         r_pc       <= i_pc;
         r_pc_plus4 <= i_pc + 32'd4;
         r_valid    <= 1'b1;
      end
   end

   assign o_ins      = r_ins;
   assign o_pc       = r_pc;
   assign o_pc_plus4 = r_pc_plus4;
   assign o_valid    = r_valid;

endmodule

`default_nettype wire

// File: rtl/ifetch.sv
// ============================================================================
// Module      : ifetch
// Description : Instruction-fetch stage: PC, imem address and IF/ID fill.
//               Define IFETCH_SYNC_EN to enable sync draining.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ifetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = c_reset_pc,
   parameter logic [31:0] NOP_INS  = c_nop_ins
)
(
   input  logic        sys_clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        stall_i,
   input  logic        hold_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        sync_i,
   input  logic        sync_done_i,
   output logic [31:0] ins_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic        ins_valid_o
);

   if_state_e r_state;
   if_state_e w_state_nxt;
   addr_t     r_fetch_pc;
   addr_t     w_fetch_pc_nxt;
   addr_t     w_pc_inc;
   logic      w_load;
   logic      w_flush;

   assign w_pc_inc = r_fetch_pc + 32'd4;

`ifndef IFETCH_SYNC_EN
   logic w_unused_sync;
   assign w_unused_sync = sync_i ^ sync_done_i;
`endif

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         r_state    <= ST_RUN;
         r_fetch_pc <= RESET_PC;
      end else begin
         r_state    <= w_state_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
      end
   end

   // r_fetch_pc is the address whose data returns this cycle; presenting it
   // again refetches the same word next cycle.
   always_comb begin
      w_state_nxt    = r_state;
      w_fetch_pc_nxt = r_fetch_pc;
      imem_addr      = r_fetch_pc;
      w_load         = 1'b0;
      w_flush        = 1'b0;
      if (!rst_n) begin
         imem_addr = RESET_PC;
      end else if (stall_i) begin
         w_state_nxt = r_state;
      end else if (redirect_i) begin
         w_fetch_pc_nxt = word_align(redirect_pc_i);
         imem_addr      = w_fetch_pc_nxt;
         w_flush        = 1'b1;
         w_state_nxt    = ST_RUN;
      end else if (hold_i) begin
         w_state_nxt = r_state;
`ifdef IFETCH_SYNC_EN
      end else if (r_state == ST_SYNC) begin
         w_flush = 1'b1;
         if (sync_done_i) begin
            w_state_nxt = ST_RUN;
         end
      end else if (r_state == ST_RUN && sync_i && ins_valid_o) begin
         // The sync moves on to EX; the word returned now is dropped.
         w_flush     = 1'b1;
         w_state_nxt = ST_SYNC;
`endif
      end else if (imem_ready) begin
         w_load         = 1'b1;
         w_fetch_pc_nxt = w_pc_inc;
         imem_addr      = w_pc_inc;
         w_state_nxt    = ST_RUN;
      end else begin
         w_flush     = 1'b1;
         w_state_nxt = ST_MEMWAIT;
      end
   end

   ifid_reg #(
      .NOP_INS (NOP_INS)
   ) u_ifid (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .i_load     (w_load),
      .i_flush    (w_flush),
      .i_ins      (imem_rdata),
      .i_pc       (r_fetch_pc),
      .o_ins      (ins_o),
      .o_pc       (pc_o),
      .o_pc_plus4 (pc_plus4_o),
      .o_valid    (ins_valid_o)
   );

endmodule

`default_nettype wire

// File: tb/tb_ifetch.sv
// ============================================================================
// Module      : tb_ifetch
// Description : Randomised self-checking bench for ifetch with a reference
//               model; follows IFETCH_SYNC_EN the same way as the design.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ifetch;

   localparam logic [31:0] c_reset_pc = 32'h0000_0000;
   localparam logic [31:0] c_nop      = 32'h0000_0000;

   logic        sys_clk = 1'b0;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall_i;
   logic        hold_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        sync_i;
   logic        sync_done_i;
   logic [31:0] ins_o;
   logic [31:0] pc_o;
   logic [31:0] pc_plus4_o;
   logic        ins_valid_o;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: next word to deliver, IF/ID contents, sync drain flag
   logic [31:0] m_fetch, m_ins, m_pc, m_pc4, mem_last;
   bit          m_valid, m_sync;

   always #5 sys_clk = ~sys_clk;

   ifetch u_dut (
      .sys_clk       (sys_clk),
      .rst_n         (rst_n),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .stall_i       (stall_i),
      .hold_i        (hold_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .sync_i        (sync_i),
      .sync_done_i   (sync_done_i),
      .ins_o         (ins_o),
      .pc_o          (pc_o),
      .pc_plus4_o    (pc_plus4_o),
      .ins_valid_o   (ins_valid_o)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h2008_0001 + a;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: apply inputs at the falling edge, check imem_addr, then
   // advance the model at the rising edge and check the IF/ID outputs.
   task automatic cycle(input bit rst, input bit st, input bit rd, input logic [31:0] tgt,
                        input bit hd, input bit sy, input bit dn, input bit rdy);
      logic [31:0] exp_addr;
      logic [31:0] presented;
      bit          drain;
      rst_n         = ~rst;
      stall_i       = st;
      redirect_i    = rd;
      redirect_pc_i = tgt;
      hold_i        = hd;
      sync_i        = sy;
      sync_done_i   = dn;
      imem_ready    = rdy;
      imem_rdata    = rdy ? mem_word(mem_last) : ($urandom | 32'h8000_0000);
      drain = 1'b0;
`ifdef IFETCH_SYNC_EN
      drain = m_sync || (sy && m_valid);
`endif
      #1;
      if (rst)                 exp_addr = c_reset_pc;
      else if (st)             exp_addr = m_fetch;
      else if (rd)             exp_addr = tgt & ~32'h3;
      else if (hd || drain)    exp_addr = m_fetch;
      else if (rdy)            exp_addr = m_fetch + 32'd4;
      else                     exp_addr = m_fetch;
      check_val("imem_addr", imem_addr, exp_addr);
      presented = imem_addr;
      @(posedge sys_clk);
      mem_last = presented;
      if (rst) begin
         m_fetch = c_reset_pc; m_ins = c_nop; m_pc = 32'h0; m_pc4 = 32'h4;
         m_valid = 1'b0; m_sync = 1'b0;
      end else if (st) begin
         m_sync = m_sync;
      end else if (rd) begin
         m_fetch = tgt & ~32'h3; m_ins = c_nop; m_valid = 1'b0; m_sync = 1'b0;
      end else if (hd) begin
         m_sync = m_sync;
`ifdef IFETCH_SYNC_EN
      end else if (m_sync) begin
         m_ins = c_nop; m_valid = 1'b0;
         if (dn) m_sync = 1'b0;
      end else if (sy && m_valid) begin
         m_ins = c_nop; m_valid = 1'b0; m_sync = 1'b1;
`endif
      end else if (rdy) begin
         m_ins = mem_word(m_fetch); m_pc = m_fetch; m_pc4 = m_fetch + 32'd4;
         m_valid = 1'b1; m_fetch = m_fetch + 32'd4;
      end else begin
         m_ins = c_nop; m_valid = 1'b0;
      end
      #1;
      check_val("ins_valid_o", {31'b0, ins_valid_o}, {31'b0, m_valid});
      check_val("ins_o", ins_o, m_ins);
      if (m_valid || rst) begin
         check_val("pc_o", pc_o, m_pc);
         check_val("pc_plus4_o", pc_plus4_o, m_pc4);
      end
      @(negedge sys_clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'h0, 0, 0, 0, 1);
   endtask

   initial begin
      m_fetch = c_reset_pc; m_ins = c_nop; m_pc = 0; m_pc4 = 4;
      m_valid = 0; m_sync = 0; mem_last = c_reset_pc;
      @(negedge sys_clk);
      // reset with late imem_ready asserted, then straight-line fetch
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 32'h0, 0, 0, 0, 1);
      run(3);
      // hold two cycles with pc_o = 0x8
      cycle(0, 0, 0, 32'h0, 1, 0, 0, 1);
      cycle(0, 0, 0, 32'h0, 1, 0, 0, 1);
      run(2);
      // redirect to unaligned target, then redirect racing a hold
      cycle(0, 0, 1, 32'h0000_0103, 0, 0, 0, 1);
      run(3);
      cycle(0, 0, 1, 32'h0000_0200, 1, 0, 0, 1);
      run(2);
      // memory not ready for three cycles
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 32'h0, 0, 0, 0, 0);
      run(3);
      // global stall
      cycle(0, 1, 0, 32'h0, 1, 0, 0, 1);
      cycle(0, 1, 1, 32'h0000_0400, 0, 0, 0, 0);
      run(2);
      // address wrap
      cycle(0, 0, 1, 32'hFFFF_FFF8, 0, 0, 0, 1);
      run(4);
      // sync at 0x20, done four cycles later
      cycle(0, 0, 1, 32'h0000_0020, 0, 0, 0, 1);
      run(1);
      cycle(0, 0, 0, 32'h0, 0, 1, 0, 1);
      run(3);
      cycle(0, 0, 0, 32'h0, 0, 0, 1, 1);
      run(3);
      // reset asserted while draining a sync
      cycle(0, 0, 1, 32'h0000_0020, 0, 0, 0, 1);
      run(1);
      cycle(0, 0, 0, 32'h0, 0, 1, 0, 1);
      run(2);
      cycle(1, 0, 0, 32'h0, 0, 0, 0, 1);
      cycle(1, 0, 0, 32'h0, 0, 0, 1, 1);
      run(3);
      // randomised traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] tgt;
         tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
         cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 11) == 0, tgt, $urandom_range(0, 7) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) != 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ifetch.md
# ifetch

Instruction-fetch stage of the five-stage pipeline. It owns the program counter, drives the synchronous instruction memory and fills the IF/ID pipeline register that feeds the decoder. It:
- holds on load-use bubbles and global stalls;
- flushes and redirects on branches and jumps resolved in EX;
- drains the pipeline on sync instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset
- NOP_INS, 32'h0000_0000, word placed in IF/ID on flush or bubble (sll $0,$0,0)

Ports:
- sys_clk  in  1  clock; reset rst_n, synchronous, active-low
- rst_n  in  1  synchronous active-low reset
- imem_addr  out  32  word-aligned fetch address; memory registers it and returns data next cycle
- imem_ready  in  1  imem_rdata valid this cycle for the previous imem_addr
- imem_rdata  in  32  instruction word
- stall_i  in  1  global freeze (is_stalling); nothing in this block changes state
- hold_i  in  1  load-use bubble from ID; IF/ID and PC hold
- redirect_i  in  1  branch taken / jump resolved in EX
- redirect_pc_i  in  32  target; bits [1:0] forced to 0
- sync_i  in  1  instruction currently in IF/ID is a sync
- sync_done_i  in  1  one-cycle pulse from MEM: all older stores committed
- ins_o  out  32  IF/ID instruction
- pc_o  out  32  IF/ID instruction address
- pc_plus4_o  out  32  pc_o + 4 (link value)
- ins_valid_o  out  1  IF/ID holds a real instruction

## Operation
- Registers:
  - fetch_pc_q: address whose data returns this cycle.
  - IF/ID: ins_q, pc_q, valid_q.
  - state_q.
- States:
  - RUN: normal.
  - MEMWAIT: imem_ready low; re-present fetch_pc_q.
  - SYNC: drain, sync_done_i not yet seen.
- Priority per cycle: reset > stall_i > redirect_i > hold_i > sync > imem_ready.
- stall_i: all registers keep value; imem_addr = fetch_pc_q.
- redirect_i (any state except during stall):
  - IF/ID <= NOP_INS, valid 0.
  - The in-flight word is discarded.
  - imem_addr = redirect_pc_i; fetch_pc_q <= redirect_pc_i; state <= RUN.
  - Aborts SYNC.
- hold_i: IF/ID keeps value; imem_addr = fetch_pc_q (refetch same word); fetch_pc_q unchanged.
- RUN with imem_ready:
  - IF/ID <= {imem_rdata, fetch_pc_q}, valid 1.
  - fetch_pc_q <= fetch_pc_q+4; imem_addr = fetch_pc_q+4.
- RUN without imem_ready: IF/ID <= NOP, valid 0; state <= MEMWAIT; imem_addr = fetch_pc_q.
- MEMWAIT: same as RUN, but returns to RUN on the first imem_ready.
- sync_i && valid_q in RUN (not held or redirected):
  - The sync instruction advances to EX normally.
  - IF/ID <= NOP, valid 0; state <= SYNC.
  - fetch_pc_q keeps pc of the instruction after the sync; the returned word is discarded.
- SYNC:
  - IF/ID emits NOP, valid 0; imem_addr = fetch_pc_q.
  - On sync_done_i, state <= RUN, and the returned word is captured next cycle.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0. No delay slots.
- Reset values:
  - fetch_pc_q = RESET_PC; imem_addr = RESET_PC during reset.
  - ins_o = NOP_INS, pc_o = 0, pc_plus4_o = 4, ins_valid_o = 0.
  - state = RUN.
- Reset mid-MEMWAIT or mid-SYNC: returns to RUN at RESET_PC; any late imem_ready is ignored.

## Timing
- Fetch latency: address in cycle N, instruction visible on ins_o in cycle N+1 (imem_ready at N+1).
- First instruction after reset release: ins_valid_o high 1 cycle after rst_n rises.
- Redirect penalty: redirect in cycle N, ins_o = NOP at N+1, target instruction at N+2.
- hold_i: IF/ID outputs stable for exactly the held cycles; no instruction lost or duplicated.
- Sync: NOP emitted from the cycle after the sync leaves ID until 1 cycle after sync_done_i.
- All outputs are registered except imem_addr, which is combinational from the state and inputs above.

## Configuration
- IFETCH_SYNC_EN defined: SYNC state and sync_i/sync_done_i are honoured as above.
- Undefined: sync_i and sync_done_i are ignored, the SYNC state is absent, and sync behaves as an ordinary instruction.

## Structure
- Shared package `cpu_pkg`: NOP_INS, RESET_PC default, the state enum {RUN, MEMWAIT, SYNC} and the 32-bit address typedef.
- One sub-module, `ifid_reg`: the IF/ID register with load/hold/flush controls.
- PC and FSM logic stays in `ifetch`.

## Test plan
- Reset release, imem_ready=1, words 0x20080001.. at 0x0,0x4 -> ins_o=0x20080001/pc_o=0 at cycle 1, pc_o=4 at cycle 2, pc_plus4_o=8.
- hold_i high 2 cycles at pc_o=0x8 -> ins_o/pc_o stable 2 cycles, then pc_o=0xC, no skipped address.
- redirect_i with redirect_pc_i=0x103 at cycle N -> NOP/valid 0 at N+1, pc_o=0x100 at N+2.
- redirect_i and hold_i same cycle -> redirect wins, IF/ID flushed, target fetched.
- imem_ready low 3 cycles -> valid 0 for 3 cycles, imem_addr constant, then sequence resumes without gap.
- With IFETCH_SYNC_EN: sync at pc 0x20, sync_done_i 4 cycles later -> NOPs in between, then pc_o=0x24. Reset asserted during SYNC -> pc_o restarts at RESET_PC.
